// File: rtl/io_bus_ctrl.sv
// Purpose : memory-mapped IO controller (LED, 7-seg handshake out, debounced button-qualified switch input).
// Latency : io_din combinational from io_addr; writes/side effects land on the next clk edge; sw/btn 2-flop sync.
// Backpr. : OUT_DATA writes are dropped while seg_valid=1; seg_valid clears on seg_valid & seg_ack.
//
// Optional feature macro: IO_CYCLE_CNT_EN adds a 32-bit free-running cycle counter at 0x18
// (write clears). Without it 0x18 reads 0 and writes to it are dropped.
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   io_addr/io_dout/io_we/io_rd CPU MEM-stage IO bus; io_din read data (combinational)
//   sw, btn                    raw asynchronous switches and "enter" button
//   led                        LED register
//   seg_data/seg_valid/seg_ack value offered to the display driver with valid/ack handshake
//
// Register map (word address io_addr[7:2]):
//   0x00 LED (R/W)   0x04 IN_STAT (R)   0x08 IN_DATA (R, clears in_valid/overrun)
//   0x0C OUT_STAT (R) 0x10 OUT_DATA (W)  0x14 SW_RAW (R)   0x18 CYCLE_CNT (optional)
module io_bus_ctrl #(
  parameter int SW_W            = 16,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [7:0]      io_addr,
  input  logic [31:0]     io_dout,
  input  logic            io_we,
  input  logic            io_rd,
  output logic [31:0]     io_din,
  input  logic [SW_W-1:0] sw,
  input  logic            btn,
  output logic [SW_W-1:0] led,
  output logic [31:0]     seg_data,
  output logic            seg_valid,
  input  logic            seg_ack
);

  localparam logic [5:0] A_LED      = 6'h00;
  localparam logic [5:0] A_IN_STAT  = 6'h01;
  localparam logic [5:0] A_IN_DATA  = 6'h02;
  localparam logic [5:0] A_OUT_STAT = 6'h03;
  localparam logic [5:0] A_OUT_DATA = 6'h04;
  localparam logic [5:0] A_SW_RAW   = 6'h05;
`ifdef IO_CYCLE_CNT_EN
  localparam logic [5:0] A_CYC_CNT  = 6'h06;
`endif
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Byte offset within the word is ignored by the decoder.
  logic [5:0] w_word;
  logic       w_unused_addr;
  assign w_word        = io_addr[7:2];
  assign w_unused_addr = ^io_addr[1:0];

  // Two-flop synchronisers.
  logic [SW_W-1:0] r_sw_s1, r_sw_s2;
  logic            r_btn_s1, r_btn_s2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
    end else begin
      r_sw_s1  <= sw;
      r_sw_s2  <= r_sw_s1;
      r_btn_s1 <= btn;
      r_btn_s2 <= r_btn_s1;
    end
  end

  // Debounce: the counter only runs while the synchronised button disagrees
  // with the debounced state, so any glitch shorter than DEBOUNCE_CYCLES resets it.
  logic [CNT_W-1:0] r_db_cnt;
  logic             r_btn_db;
  logic             r_btn_db_q;
  logic             w_press;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_db_cnt   <= '0;
      r_btn_db   <= 1'b0;
      r_btn_db_q <= 1'b0;
    end else begin
      r_btn_db_q <= r_btn_db;
      if (r_btn_s2 == r_btn_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_btn_db <= ~r_btn_db;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + CNT_W'(1);
      end
    end
  end

  assign w_press = r_btn_db & ~r_btn_db_q;

  // Bus strobes.
  logic w_wr_led, w_wr_out, w_rd_in_data;
  assign w_wr_led     = io_we & (w_word == A_LED);
  assign w_wr_out     = io_we & (w_word == A_OUT_DATA);
  assign w_rd_in_data = io_rd & (w_word == A_IN_DATA);

  // LED register.
  logic [SW_W-1:0] r_led;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_led <= '0;
    end else if (w_wr_led) begin
      r_led <= io_dout[SW_W-1:0];
    end
  end
  assign led = r_led;

  // Input channel. A press coinciding with an IN_DATA read wins: the read
  // sees the old data, the new sample is captured and overrun starts clean.
  logic [SW_W-1:0] r_in_data;
  logic            r_in_valid;
  logic            r_overrun;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_in_data  <= '0;
      r_in_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else if (w_press && (!r_in_valid || w_rd_in_data)) begin
      r_in_data  <= r_sw_s2;
      r_in_valid <= 1'b1;
      r_overrun  <= 1'b0;
    end else if (w_press) begin
      r_overrun  <= 1'b1;
    end else if (w_rd_in_data) begin
      r_in_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end
  end

  // Output channel. A write in the transfer cycle is dropped because
  // seg_valid was still 1 when it was sampled.
  logic [31:0] r_seg_data;
  logic        r_seg_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_seg_data  <= '0;
      r_seg_valid <= 1'b0;
    end else if (r_seg_valid) begin
      if (seg_ack) begin
        r_seg_valid <= 1'b0;
      end
    end else if (w_wr_out) begin
      r_seg_data  <= io_dout;
      r_seg_valid <= 1'b1;
    end
  end
  assign seg_data  = r_seg_data;
  assign seg_valid = r_seg_valid;

`ifdef IO_CYCLE_CNT_EN
  logic [31:0] r_cyc_cnt;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cyc_cnt <= '0;
    end else if (io_we && (w_word == A_CYC_CNT)) begin
      r_cyc_cnt <= '0;
    end else begin
      r_cyc_cnt <= r_cyc_cnt + 32'd1;
    end
  end
`endif

  // Read mux: reflects pre-edge contents, so a same-cycle write is not visible.
  always_comb begin
    io_din = 32'd0;
    case (w_word)
      A_LED:      io_din = 32'(r_led);
      A_IN_STAT:  io_din = {30'd0, r_overrun, r_in_valid};
      A_IN_DATA:  io_din = 32'(r_in_data);
      A_OUT_STAT: io_din = {31'd0, ~r_seg_valid};
      A_SW_RAW:   io_din = 32'(r_sw_s2);
`ifdef IO_CYCLE_CNT_EN
      A_CYC_CNT:  io_din = r_cyc_cnt;
`endif
      default:    io_din = 32'd0;
    endcase
  end

endmodule
